// File: rtl/thread_dispatcher_pkg.sv
// Shared types and default sizing for the thread-to-ALU dispatcher.
package thread_dispatcher_pkg;

  // Smallest vector width able to index 'count' distinct values (never below 1).
  function automatic int min_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int NUM_THREADS = 8;
  localparam int NUM_ALUS    = 4;
  localparam int TID_W       = min_width(NUM_THREADS);

  typedef enum logic {
    DISP_STATIC = 1'b0,
    DISP_RR     = 1'b1
  } dispatch_mode_e;

  typedef logic [TID_W-1:0] tid_t;

endpackage

// File: rtl/thread_dispatcher_if.sv
// Bundle of thread status inputs and per-lane dispatch outputs.
// The master side (core control / bench) drives status; the slave side is the dispatcher.
interface thread_dispatcher_if #(
  parameter int NUM_THREADS = thread_dispatcher_pkg::NUM_THREADS,
  parameter int NUM_ALUS    = thread_dispatcher_pkg::NUM_ALUS,
  parameter int TID_W       = thread_dispatcher_pkg::TID_W
);

  logic                             mode_i;
  logic [NUM_THREADS-1:0]           thread_ready_i;
  logic [NUM_THREADS-1:0]           thread_hold_i;
  logic [NUM_THREADS-1:0]           prio_mask_i;
  logic [NUM_ALUS-1:0]              alu_busy_i;
  logic [NUM_ALUS-1:0]              dispatch_valid_o;
  logic [NUM_ALUS-1:0][TID_W-1:0]   dispatch_tid_o;
  logic [NUM_THREADS-1:0]           thread_grant_o;
  logic [NUM_THREADS-1:0]           starve_o;

  modport master (
    output mode_i,
    output thread_ready_i,
    output thread_hold_i,
    output prio_mask_i,
    output alu_busy_i,
    input  dispatch_valid_o,
    input  dispatch_tid_o,
    input  thread_grant_o,
    input  starve_o
  );

  modport slave (
    input  mode_i,
    input  thread_ready_i,
    input  thread_hold_i,
    input  prio_mask_i,
    input  alu_busy_i,
    output dispatch_valid_o,
    output dispatch_tid_o,
    output thread_grant_o,
    output starve_o
  );

endinterface

// File: rtl/thread_pick.sv
// Combinational rotating-priority picker: returns the first requester found
// when scanning start_i, start_i+1, ... and wrapping modulo N.
module thread_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] pos;

  // Walk the request vector from the start pointer and latch onto the first hit.
  always_comb begin
    found_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    pos      = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, start_i} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!found_o && req_i[pos[IW-1:0]]) begin
        found_o                 = 1'b1;
        idx_o                   = pos[IW-1:0];
        onehot_o[pos[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_dispatcher.sv
// Registered thread-to-ALU scheduler: maps up to NUM_ALUS eligible threads onto
// free lanes each cycle using starvation promotion, a priority mask and a
// round-robin pointer, with a per-thread cooldown after a jump/hold pulse.
module thread_dispatcher #(
  parameter int NUM_THREADS  = thread_dispatcher_pkg::NUM_THREADS,
  parameter int NUM_ALUS     = thread_dispatcher_pkg::NUM_ALUS,
  parameter int TID_W        = thread_dispatcher_pkg::min_width(NUM_THREADS),
  parameter int FLUSH_CYCLES = 2,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_W        = thread_dispatcher_pkg::min_width(STARVE_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  thread_dispatcher_if.slave bus
);

  import thread_dispatcher_pkg::*;

  localparam int                COOL_W    = min_width(FLUSH_CYCLES + 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0]  WAIT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic [TID_W-1:0]  TID_LAST  = TID_W'(NUM_THREADS - 1);

  // Threads a static-mode lane may serve: tid mod NUM_ALUS == lane.
  function automatic logic [NUM_THREADS-1:0] lane_mask(input int lane);
    logic [NUM_THREADS-1:0] m;
    m = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      m[t] = ((t % NUM_ALUS) == lane);
    end
    return m;
  endfunction

  dispatch_mode_e mode;
  assign mode = dispatch_mode_e'(bus.mode_i);

  // Registered state
  logic [NUM_ALUS-1:0]                 valid_q, valid_d;
  logic [NUM_ALUS-1:0][TID_W-1:0]      tid_q, tid_d;
  logic [NUM_THREADS-1:0]              grant_q, grant_d;
  logic [TID_W-1:0]                    rr_q, rr_d;
  logic [NUM_THREADS-1:0][COOL_W-1:0]  cool_q, cool_d;
  logic [NUM_THREADS-1:0][CNT_W-1:0]   wait_q, wait_d;

  // Per-thread classification
  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] starved;
  logic [NUM_THREADS-1:0] cls_a, cls_b, cls_c;

  // Eligibility needs a ready instruction, no hold this cycle and an expired cooldown.
  always_comb begin
    elig    = '0;
    starved = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      elig[t]    = bus.thread_ready_i[t] & ~bus.thread_hold_i[t] &
                   ((FLUSH_CYCLES == 0) || (cool_q[t] == '0));
      starved[t] = (wait_q[t] == WAIT_MAX);
    end
  end

  assign cls_a = elig & starved;
  assign cls_b = elig & ~starved & bus.prio_mask_i;
  assign cls_c = elig & ~starved & ~bus.prio_mask_i;

  // Per-lane picks. In round-robin mode each lane sees only the threads not yet
  // taken by lower lanes; a busy lane takes nothing so the next free lane gets
  // the same candidate. In static mode each lane sees its own residue class.
  logic [NUM_THREADS-1:0] rem         [NUM_ALUS];
  logic [NUM_THREADS-1:0] pick_onehot [NUM_ALUS];
  logic [TID_W-1:0]       pick_idx    [NUM_ALUS];
  logic                   lane_hit    [NUM_ALUS];

  assign rem[0] = '1;

  for (genvar a = 0; a < NUM_ALUS; a++) begin : g_lane
    logic [NUM_THREADS-1:0] avail;
    logic [NUM_THREADS-1:0] req_a, req_b, req_c, req;
    logic                   found;

    assign avail = (mode == DISP_RR) ? rem[a] : lane_mask(a);
    assign req_a = cls_a & avail;
    assign req_b = cls_b & avail;
    assign req_c = cls_c & avail;
    assign req   = (|req_a) ? req_a : ((|req_b) ? req_b : req_c);

    thread_pick #(
      .N  (NUM_THREADS),
      .IW (TID_W)
    ) u_pick (
      .req_i    (req),
      .start_i  (rr_q),
      .found_o  (found),
      .onehot_o (pick_onehot[a]),
      .idx_o    (pick_idx[a])
    );

    assign lane_hit[a] = found & ~bus.alu_busy_i[a];

    if (a < NUM_ALUS - 1) begin : g_chain
      assign rem[a+1] = lane_hit[a] ? (rem[a] & ~pick_onehot[a]) : rem[a];
    end
  end

  // Collect lane grants; the pointer follows the highest granted lane, and an
  // idle lane keeps its last tid so only valid needs to drop.
  always_comb begin
    valid_d = '0;
    tid_d   = tid_q;
    grant_d = '0;
    rr_d    = rr_q;
    for (int a = 0; a < NUM_ALUS; a++) begin
      if (lane_hit[a]) begin
        valid_d[a] = 1'b1;
        tid_d[a]   = pick_idx[a];
        grant_d    = grant_d | pick_onehot[a];
        rr_d       = (pick_idx[a] == TID_LAST) ? '0 : pick_idx[a] + TID_W'(1);
      end
    end
  end

  // Cooldown reloads on every hold pulse; wait counters track consecutive
  // eligible-but-ungranted cycles and saturate at the starvation limit.
  always_comb begin
    cool_d = '0;
    wait_d = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (bus.thread_hold_i[t]) begin
        cool_d[t] = COOL_LOAD;
      end else if (cool_q[t] != '0) begin
        cool_d[t] = cool_q[t] - COOL_W'(1);
      end

      if (elig[t] && !grant_d[t]) begin
        wait_d[t] = (wait_q[t] == WAIT_MAX) ? WAIT_MAX : wait_q[t] + CNT_W'(1);
      end
    end
  end

  // State and output registers; reset drops any in-flight grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      tid_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      cool_q  <= '0;
      wait_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tid_q   <= tid_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cool_q  <= cool_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.dispatch_valid_o = valid_q;
  assign bus.dispatch_tid_o   = tid_q;
  assign bus.thread_grant_o   = grant_q;
  assign bus.starve_o         = starved;

endmodule

// File: tb/tb_thread_dispatcher.sv
// Directed and randomised bench for thread_dispatcher: an 8-thread/4-lane
// instance for the main scenarios plus a 4-thread/4-lane static instance.
module tb_thread_dispatcher;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  thread_dispatcher_if #(.NUM_THREADS(8), .NUM_ALUS(4), .TID_W(3)) bus8 ();
  thread_dispatcher_if #(.NUM_THREADS(4), .NUM_ALUS(4), .TID_W(2)) bus4 ();

  thread_dispatcher #(
    .NUM_THREADS(8), .NUM_ALUS(4), .TID_W(3),
    .FLUSH_CYCLES(2), .STARVE_LIMIT(15), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  thread_dispatcher #(
    .NUM_THREADS(4), .NUM_ALUS(4), .TID_W(2),
    .FLUSH_CYCLES(2), .STARVE_LIMIT(15), .CNT_W(4)
  ) dut_static (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one decision's inputs, then sample 1 time unit after the registering edge.
  task automatic applyStimulus(input logic [7:0] ready, input logic [7:0] hold,
                               input logic [7:0] prio, input logic [3:0] busy,
                               input logic mode);
    bus8.thread_ready_i = ready;
    bus8.thread_hold_i  = hold;
    bus8.prio_mask_i    = prio;
    bus8.alu_busy_i     = busy;
    bus8.mode_i         = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic checkLanes(input string tag, input logic [3:0] exp_valid,
                            input int t0, input int t1, input int t2, input int t3);
    int exp_tid[4];
    exp_tid = '{t0, t1, t2, t3};
    checkOutput({tag, "_valid"}, 32'(bus8.dispatch_valid_o), 32'(exp_valid));
    for (int a = 0; a < 4; a++) begin
      if (exp_valid[a]) begin
        checkOutput($sformatf("%s_tid%0d", tag, a), 32'(bus8.dispatch_tid_o[a]), exp_tid[a]);
      end
    end
  endtask

  task automatic checkStaticInstance(input string tag);
    checkOutput({tag, "_s4_valid"}, 32'(bus4.dispatch_valid_o), 32'h0000_000F);
    for (int a = 0; a < 4; a++) begin
      checkOutput($sformatf("%s_s4_tid%0d", tag, a), 32'(bus4.dispatch_tid_o[a]), a);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus8.dispatch_valid_o), 32'h0);
    checkOutput({tag, "_grant"}, 32'(bus8.thread_grant_o), 32'h0);
    checkOutput({tag, "_starve"}, 32'(bus8.starve_o), 32'h0);
    checkOutput({tag, "_tids"}, 32'(bus8.dispatch_tid_o), 32'h0);
    checkOutput({tag, "_s4_valid"}, 32'(bus4.dispatch_valid_o), 32'h0);
  endtask

  int          tb_cool[8];
  int          tb_wait[8];
  int          max_wait;
  logic [7:0]  r_ready, r_hold, r_prio, r_elig, or_vec;
  logic [3:0]  r_busy;
  logic        r_mode;
  logic        dup, busy_hit, inelig, static_bad;
  int          tid;

  initial begin
    rst = 1'b0;
    bus8.thread_ready_i = 8'hFF;
    bus8.thread_hold_i  = 8'h00;
    bus8.prio_mask_i    = 8'h00;
    bus8.alu_busy_i     = 4'h0;
    bus8.mode_i         = 1'b1;
    bus4.thread_ready_i = 4'hF;
    bus4.thread_hold_i  = 4'h0;
    bus4.prio_mask_i    = 4'h0;
    bus4.alu_busy_i     = 4'h0;
    bus4.mode_i         = 1'b0;

    // Reset held with every thread ready
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b1;

    // Round-robin sweep after release
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b1);
    checkLanes("rr_c1", 4'hF, 0, 1, 2, 3);
    checkOutput("rr_c1_grant", 32'(bus8.thread_grant_o), 32'h0F);
    checkStaticInstance("rr_c1");
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b1);
    checkLanes("rr_c2", 4'hF, 4, 5, 6, 7);
    checkOutput("rr_c2_grant", 32'(bus8.thread_grant_o), 32'hF0);
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b1);
    checkLanes("rr_c3", 4'hF, 0, 1, 2, 3);
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b1);
    checkLanes("rr_c4", 4'hF, 4, 5, 6, 7);

    // Busy lane 1 with rr_ptr at 0
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'b0010, 1'b1);
    checkLanes("busy", 4'b1101, 0, 0, 1, 2);
    checkOutput("busy_grant", 32'(bus8.thread_grant_o), 32'h07);
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b1);
    checkLanes("after_busy", 4'hF, 3, 4, 5, 6);
    checkOutput("after_busy_grant", 32'(bus8.thread_grant_o), 32'h78);

    // Cooldown: hold thread 5 for one decision, threads 0 and 5 ready
    applyStimulus(8'h21, 8'h20, 8'h00, 4'h0, 1'b1);
    checkLanes("hold_d0", 4'b0001, 0, 0, 0, 0);
    checkOutput("hold_d0_grant", 32'(bus8.thread_grant_o), 32'h01);
    applyStimulus(8'h21, 8'h00, 8'h00, 4'h0, 1'b1);
    checkOutput("cool_d1_grant", 32'(bus8.thread_grant_o), 32'h01);
    applyStimulus(8'h21, 8'h00, 8'h00, 4'h0, 1'b1);
    checkOutput("cool_d2_grant", 32'(bus8.thread_grant_o), 32'h01);
    applyStimulus(8'h21, 8'h00, 8'h00, 4'h0, 1'b1);
    checkLanes("cool_d3", 4'b0011, 5, 0, 0, 0);
    checkOutput("cool_d3_grant", 32'(bus8.thread_grant_o), 32'h21);

    // Starvation: high-priority threads 0..3 hog all lanes, thread 6 waits
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(8'h4F, 8'h00, 8'h0F, 4'h0, 1'b1);
      checkOutput($sformatf("starve_k%0d_grant", k), 32'(bus8.thread_grant_o), 32'h0F);
      checkOutput($sformatf("starve_k%0d_flag", k), 32'(bus8.starve_o), (k == 15) ? 32'h40 : 32'h00);
      if (k == 1) begin
        checkLanes("starve_k1", 4'hF, 1, 2, 3, 0);
      end
    end
    applyStimulus(8'h4F, 8'h00, 8'h0F, 4'h0, 1'b1);
    checkLanes("promote", 4'hF, 6, 1, 2, 3);
    checkOutput("promote_grant", 32'(bus8.thread_grant_o), 32'h4E);
    checkOutput("promote_starve", 32'(bus8.starve_o), 32'h00);

    // Static mode, 8 threads: lane a serves only a and a+4
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b0);
    checkLanes("static_s1", 4'hF, 4, 5, 6, 7);
    checkStaticInstance("static_s1");
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b0);
    checkLanes("static_s2", 4'hF, 0, 1, 2, 3);
    checkStaticInstance("static_s2");
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b0);
    checkLanes("static_s3", 4'hF, 4, 5, 6, 7);
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'b0010, 1'b0);
    checkLanes("static_busy", 4'b1101, 0, 0, 2, 3);
    checkOutput("static_busy_grant", 32'(bus8.thread_grant_o), 32'h0D);
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b0);
    checkLanes("static_s5", 4'hF, 4, 5, 6, 7);
    checkStaticInstance("static_s5");

    // Asynchronous reset in the middle of a cycle
    #3;
    rst = 1'b0;
    #1;
    checkAllZero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(8'hFF, 8'h00, 8'h00, 4'h0, 1'b1);
    checkLanes("post_reset", 4'hF, 0, 1, 2, 3);

    // Random soak with invariant checks against a bench-side cooldown model
    for (int t = 0; t < 8; t++) begin
      tb_cool[t] = 0;
      tb_wait[t] = 0;
    end
    max_wait = 0;
    r_mode   = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r_ready = 8'($urandom);
      r_hold  = 8'($urandom & $urandom & $urandom);
      r_prio  = 8'($urandom);
      r_busy  = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 199) == 0) r_mode = ~r_mode;
      for (int t = 0; t < 8; t++) begin
        r_elig[t] = r_ready[t] & ~r_hold[t] & (tb_cool[t] == 0);
      end

      applyStimulus(r_ready, r_hold, r_prio, r_busy, r_mode);

      dup = 1'b0; busy_hit = 1'b0; inelig = 1'b0; static_bad = 1'b0; or_vec = '0;
      for (int a = 0; a < 4; a++) begin
        if (bus8.dispatch_valid_o[a]) begin
          tid = int'(bus8.dispatch_tid_o[a]);
          if (or_vec[tid]) dup = 1'b1;
          or_vec[tid] = 1'b1;
          if (r_busy[a]) busy_hit = 1'b1;
          if (!r_elig[tid]) inelig = 1'b1;
          if (!r_mode && ((tid % 4) != a)) static_bad = 1'b1;
        end
      end
      checkOutput("inv_dup_tid", 32'(dup), 32'h0);
      checkOutput("inv_busy_lane", 32'(busy_hit), 32'h0);
      checkOutput("inv_ineligible", 32'(inelig), 32'h0);
      checkOutput("inv_static_lane", 32'(static_bad), 32'h0);
      checkOutput("inv_grant_or", 32'(bus8.thread_grant_o), 32'(or_vec));

      for (int t = 0; t < 8; t++) begin
        if (r_hold[t]) tb_cool[t] = 2;
        else if (tb_cool[t] > 0) tb_cool[t] = tb_cool[t] - 1;
        if (r_elig[t] && !bus8.thread_grant_o[t]) tb_wait[t] = tb_wait[t] + 1;
        else tb_wait[t] = 0;
        if (tb_wait[t] > max_wait) max_wait = tb_wait[t];
      end
    end
    checkOutput("soak_wait_bound", 32'(max_wait <= 15 + 8), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
